seg7_scan_driver: RTL

Time-multiplexed 4-digit seven-segment display driver. It sits directly downstream of the synchronous BCD counter stage(s), consuming their 4-bit BCD digits. It drives the board's shared active-low cathode bus and per-digit active-low anodes. It includes a refresh divider, digit rotation, a frame-synchronous input snapshot, BCD-to-segment decode, and optional leading-zero blanking.

---
 rtl/seg7_scan_driver.sv | 75 +++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed BCD seven-segment driver with frame snapshot and leading-zero blanking
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(NUM_DIGITS);
    logic [CW-1:0]           cnt;
    logic [SW-1:0]           sel;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              digit;
    logic [6:0]              dec;
    logic                    tick;
    logic                    last;
    logic                    all_zero;
    assign tick  = cnt == CW'(REFRESH_DIV - 1);
    assign last  = sel == SW'(NUM_DIGITS - 1);
    assign digit = shadow[4*sel +: 4];
    always_comb begin
        case (digit)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = 7'b0111111;
        endcase
    end
    // a digit is blank when it and every digit to its left are zero; digit 0 always shows
    always_comb begin
        all_zero = 1'b1;
        blank    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (shadow[4*i +: 4] == 4'd0);
            blank[i] = all_zero && (i != 0);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            sel       <= '0;
            shadow    <= '0;
            shadow_dp <= '0;
            an        <= '1;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) sel <= last ? '0 : sel + 1'b1;
            if (tick && last) begin
                shadow    <= bcd_in;
                shadow_dp <= dp_in;
            end
            an  <= ~(NUM_DIGITS'(1) << sel);
            seg <= (blank_lz && blank[sel]) ? 7'h7F : dec;
            dp  <= (blank_lz && blank[sel]) ? 1'b1 : ~shadow_dp[sel];
        end
    end
endmodule
